tcam_lookup_engine: RTL and testbench

- Parametrised, self-contained ternary CAM lookup engine. Successor to the fixed 16x8 macro-driven controller.
- Holds DEPTH entries, each with key, care-mask, valid bit and associated data. Accepts one request at a time over a valid/ready handshake and returns one response per request.
- Supports write, read, invalidate, flush and priority lookup. Lookup returns the lowest-index matching entry and its data.
- Sits between the packet front-end, which supplies packet IDs as keys, and the routing stage, which consumes the destination ID in `rsp_data`.

---
 rtl/tcam_pkg.sv | 21 ++
 rtl/tcam_prio_enc.sv | 21 ++
 rtl/tcam_lookup_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_tcam_lookup_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared types and constants for the ternary CAM lookup engine.
package tcam_pkg;

  localparam int HITCNT_W = 8;

  typedef enum logic [2:0] {
    OP_WRITE  = 3'd1,
    OP_READ   = 3'd2,
    OP_FLUSH  = 3'd3,
    OP_LOOKUP = 3'd4,
    OP_INVAL  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MATCH,
    ST_FLUSH,
    ST_RESP
  } state_e;

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational priority encoder: reports whether any match bit is set
// and the index of the lowest set bit.
module tcam_prio_enc #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  match_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] idx_o
);

  always_comb begin
    hit_o = |match_i;
    idx_o = '0;
    // Scan downwards so the lowest matching index is assigned last and wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_i[i]) idx_o = ADDR_W'(i);
    end
  end

endmodule

// File: rtl/tcam_lookup_engine.sv
// Ternary CAM lookup engine: write/read/invalidate/flush/priority lookup over
// a single-outstanding valid/ready request/response pair. TCAM_HITCNT_EN adds per-entry hit counters.
module tcam_lookup_engine
  import tcam_pkg::*;
#(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [KEY_W-1:0]    req_key,
  input  logic [KEY_W-1:0]    req_mask,
  input  logic [DATA_W-1:0]   req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2:0]          rsp_op,
  output logic                rsp_err,
  output logic                rsp_hit,
  output logic [ADDR_W-1:0]   rsp_idx,
  output logic [KEY_W-1:0]    rsp_key,
  output logic [KEY_W-1:0]    rsp_mask,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [HITCNT_W-1:0] rsp_hit_cnt
);

  state_e              state_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [2:0]          rsp_op_q;
  logic                rsp_err_q;
  logic                rsp_hit_q;
  logic [ADDR_W-1:0]   rsp_idx_q;
  logic [KEY_W-1:0]    rsp_key_q;
  logic [KEY_W-1:0]    rsp_mask_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic [DEPTH-1:0]    valid_q;
  logic [KEY_W-1:0]    key_q  [DEPTH];
  logic [KEY_W-1:0]    mask_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];

  logic [DEPTH-1:0]    match_q;
  logic [ADDR_W-1:0]   flush_cnt_q;

`ifdef TCAM_HITCNT_EN
  logic [HITCNT_W-1:0] hit_cnt_q [DEPTH];
  logic [HITCNT_W-1:0] rsp_hit_cnt_q;
`endif

  logic [DEPTH-1:0]    match_d;
  logic                enc_hit;
  logic [ADDR_W-1:0]   enc_idx;
  logic                addr_ok;

  // Catches indices past the last entry when DEPTH is not a power of two.
  assign addr_ok = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_d[gi] = valid_q[gi] &&
                         (((req_key ^ key_q[gi]) & mask_q[gi] & req_mask) == '0);
  end

  tcam_prio_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prio_enc (
    .match_i (match_q),
    .hit_o   (enc_hit),
    .idx_o   (enc_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_key_q   <= '0;
      rsp_mask_q  <= '0;
      rsp_data_q  <= '0;
      valid_q     <= '0;
      match_q     <= '0;
      flush_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= '0;
        mask_q[i] <= '0;
        data_q[i] <= '0;
      end
`ifdef TCAM_HITCNT_EN
      rsp_hit_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) hit_cnt_q[i] <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rsp_op_q    <= req_op;
            rsp_err_q   <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= req_addr;
            rsp_key_q   <= '0;
            rsp_mask_q  <= '0;
            rsp_data_q  <= '0;
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
`ifdef TCAM_HITCNT_EN
            rsp_hit_cnt_q <= '0;
`endif
            case (req_op)
              OP_WRITE: begin
                if (addr_ok) begin
                  key_q[req_addr]   <= req_key;
                  mask_q[req_addr]  <= req_mask;
                  data_q[req_addr]  <= req_data;
                  valid_q[req_addr] <= 1'b1;
`ifdef TCAM_HITCNT_EN
                  hit_cnt_q[req_addr] <= '0;
`endif
                end else begin
                  rsp_err_q <= 1'b1;
                  rsp_idx_q <= '0;
                end
              end
              OP_READ: begin
                if (addr_ok) begin
                  rsp_hit_q  <= valid_q[req_addr];
                  rsp_key_q  <= key_q[req_addr];
                  rsp_mask_q <= mask_q[req_addr];
                  rsp_data_q <= data_q[req_addr];
`ifdef TCAM_HITCNT_EN
                  rsp_hit_cnt_q <= hit_cnt_q[req_addr];
`endif
                end else begin
                  rsp_err_q <= 1'b1;
                  rsp_idx_q <= '0;
                end
              end
              OP_INVAL: begin
                if (addr_ok) begin
                  valid_q[req_addr] <= 1'b0;
`ifdef TCAM_HITCNT_EN
                  hit_cnt_q[req_addr] <= '0;
`endif
                end else begin
                  rsp_err_q <= 1'b1;
                  rsp_idx_q <= '0;
                end
              end
              OP_LOOKUP: begin
                match_q     <= match_d;
                state_q     <= ST_MATCH;
                rsp_valid_q <= 1'b0;
              end
              OP_FLUSH: begin
                flush_cnt_q <= '0;
                state_q     <= ST_FLUSH;
                rsp_valid_q <= 1'b0;
              end
              default: begin
                rsp_err_q <= 1'b1;
                rsp_idx_q <= '0;
              end
            endcase
          end
        end

        ST_MATCH: begin
          rsp_hit_q   <= enc_hit;
          rsp_idx_q   <= enc_hit ? enc_idx : '0;
          rsp_data_q  <= enc_hit ? data_q[enc_idx] : '0;
`ifdef TCAM_HITCNT_EN
          if (enc_hit && (hit_cnt_q[enc_idx] != {HITCNT_W{1'b1}}))
            hit_cnt_q[enc_idx] <= hit_cnt_q[enc_idx] + 1'b1;
`endif
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end

        ST_FLUSH: begin
          valid_q[flush_cnt_q] <= 1'b0;
`ifdef TCAM_HITCNT_EN
          hit_cnt_q[flush_cnt_q] <= '0;
`endif
          if (flush_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_key   = rsp_key_q;
  assign rsp_mask  = rsp_mask_q;
  assign rsp_data  = rsp_data_q;

`ifdef TCAM_HITCNT_EN
  assign rsp_hit_cnt = rsp_hit_cnt_q;
`else
  assign rsp_hit_cnt = '0;
`endif

endmodule

// File: tb/tb_tcam_lookup_engine.sv
// Directed self-checking bench for tcam_lookup_engine (default 16x8, data 4).
module tb_tcam_lookup_engine;
  import tcam_pkg::*;

  localparam int KEY_W  = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int BOUND  = 50;

`ifdef TCAM_HITCNT_EN
  localparam int N_HITS   = 300;
  localparam int EXP_HCNT = 255;
`else
  localparam int N_HITS   = 3;
  localparam int EXP_HCNT = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [2:0]          req_op = '0;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [KEY_W-1:0]    req_key = '0;
  logic [KEY_W-1:0]    req_mask = '0;
  logic [DATA_W-1:0]   req_data = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [2:0]          rsp_op;
  logic                rsp_err;
  logic                rsp_hit;
  logic [ADDR_W-1:0]   rsp_idx;
  logic [KEY_W-1:0]    rsp_key;
  logic [KEY_W-1:0]    rsp_mask;
  logic [DATA_W-1:0]   rsp_data;
  logic [HITCNT_W-1:0] rsp_hit_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  tcam_lookup_engine #(
    .KEY_W  (KEY_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_key     (req_key),
    .req_mask    (req_mask),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_op      (rsp_op),
    .rsp_err     (rsp_err),
    .rsp_hit     (rsp_hit),
    .rsp_idx     (rsp_idx),
    .rsp_key     (rsp_key),
    .rsp_mask    (rsp_mask),
    .rsp_data    (rsp_data),
    .rsp_hit_cnt (rsp_hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response is first visible.
  // lat counts rising edges from the handshake edge (inclusive) to that point.
  task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                      input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] mask,
                      input logic [DATA_W-1:0] data);
    int guard = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_key   = key;
    req_mask  = mask;
    req_data  = data;
    while (!req_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    check("hs_bound", 32'(guard < BOUND), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < BOUND) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    $display("txn op=%0d addr=%0d key=%02h mask=%02h data=%0h -> lat=%0d err=%0b hit=%0b idx=%0d rkey=%02h rdata=%0h hcnt=%0d",
             op, addr, key, mask, data, lat, rsp_err, rsp_hit, rsp_idx, rsp_key, rsp_data, rsp_hit_cnt);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic lookup_chk(input string tag, input logic [KEY_W-1:0] key,
                            input logic [KEY_W-1:0] mask, input logic exp_hit,
                            input logic [ADDR_W-1:0] exp_idx, input logic [DATA_W-1:0] exp_data);
    send(OP_LOOKUP, '0, key, mask, '0);
    check({tag, "_lat"},  lat, 2);
    check({tag, "_hit"},  32'(rsp_hit), 32'(exp_hit));
    check({tag, "_idx"},  32'(rsp_idx), 32'(exp_idx));
    check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
    ack();
  endtask

  task automatic write_entry(input logic [ADDR_W-1:0] addr, input logic [KEY_W-1:0] key,
                             input logic [KEY_W-1:0] mask, input logic [DATA_W-1:0] data);
    send(OP_WRITE, addr, key, mask, data);
    check("wr_err", 32'(rsp_err), 0);
    ack();
  endtask

  initial begin
    logic [2:0]        s_op;
    logic              s_hit;
    logic [ADDR_W-1:0] s_idx;
    logic [DATA_W-1:0] s_data;
    logic              stable;
    logic              ready_seen;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err",   32'(rsp_err), 0);
    check("rst_rsp_hit",   32'(rsp_hit), 0);
    check("rst_rsp_data",  32'(rsp_data), 0);
    check("rst_rsp_key",   32'(rsp_key), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back one entry.
    send(OP_WRITE, 4'd3, 8'hA5, 8'hFF, 4'h7);
    check("wr3_lat", lat, 1);
    check("wr3_err", 32'(rsp_err), 0);
    check("wr3_idx", 32'(rsp_idx), 3);
    check("wr3_op",  32'(rsp_op), 1);
    ack();
    send(OP_READ, 4'd3, '0, '0, '0);
    check("rd3_lat",  lat, 1);
    check("rd3_hit",  32'(rsp_hit), 1);
    check("rd3_key",  32'(rsp_key), 32'hA5);
    check("rd3_mask", 32'(rsp_mask), 32'hFF);
    check("rd3_data", 32'(rsp_data), 32'h7);
    check("rd3_hcnt", 32'(rsp_hit_cnt), 0);
    ack();

    // Invalidate entry 3 so it does not shadow the priority tests below.
    send(OP_INVAL, 4'd3, '0, '0, '0);
    check("inv3_err", 32'(rsp_err), 0);
    ack();
    send(OP_READ, 4'd3, '0, '0, '0);
    check("rd3inv_hit", 32'(rsp_hit), 0);
    check("rd3inv_key", 32'(rsp_key), 32'hA5);
    ack();

    write_entry(4'd2, 8'hA0, 8'hF0, 4'h1);
    write_entry(4'd5, 8'hA5, 8'hFF, 4'h2);
    lookup_chk("lk_prio2", 8'hA5, 8'hFF, 1'b1, 4'd2, 4'h1);
    send(OP_INVAL, 4'd2, '0, '0, '0);
    ack();
    lookup_chk("lk_after_inv", 8'hA5, 8'hFF, 1'b1, 4'd5, 4'h2);
    lookup_chk("lk_miss",      8'h3C, 8'hFF, 1'b0, 4'd0, 4'h0);
    lookup_chk("lk_gmask0",    8'h3C, 8'h00, 1'b1, 4'd5, 4'h2);
    write_entry(4'd9, 8'h00, 8'h00, 4'hC);
    lookup_chk("lk_wild",      8'h3C, 8'hFF, 1'b1, 4'd9, 4'hC);
    lookup_chk("lk_low_wins",  8'hA5, 8'hFF, 1'b1, 4'd5, 4'h2);

    // Illegal opcodes.
    send(3'd7, 4'd6, 8'h12, 8'h34, 4'h5);
    check("ill7_lat", lat, 1);
    check("ill7_err", 32'(rsp_err), 1);
    check("ill7_op",  32'(rsp_op), 7);
    check("ill7_idx", 32'(rsp_idx), 0);
    check("ill7_hit", 32'(rsp_hit), 0);
    ack();
    send(3'd0, 4'd1, '0, '0, '0);
    check("ill0_err", 32'(rsp_err), 1);
    ack();

    // Stalled response must hold steady and block new requests.
    send(OP_LOOKUP, '0, 8'hA5, 8'hFF, '0);
    s_op = rsp_op; s_hit = rsp_hit; s_idx = rsp_idx; s_data = rsp_data;
    check("stall_hit",  32'(s_hit), 1);
    check("stall_idx",  32'(s_idx), 5);
    stable = 1'b1;
    ready_seen = 1'b0;
    req_valid = 1'b1;
    req_op = OP_WRITE;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_op != s_op || rsp_hit != s_hit || rsp_idx != s_idx || rsp_data != s_data)
        stable = 1'b0;
      if (req_ready) ready_seen = 1'b1;
    end
    req_valid = 1'b0;
    check("stall_stable", 32'(stable), 1);
    check("stall_ready",  32'(ready_seen), 0);
    ack();
    lookup_chk("stall_nowrite", 8'h00, 8'h00, 1'b1, 4'd5, 4'h2);

    // Flush.
    send(OP_FLUSH, '0, '0, '0, '0);
    check("flush_lat",   lat, DEPTH + 1);
    check("flush_err",   32'(rsp_err), 0);
    check("flush_ready", 32'(req_ready), 0);
    ack();
    lookup_chk("post_flush",    8'hA5, 8'hFF, 1'b0, 4'd0, 4'h0);
    lookup_chk("post_flush_wc", 8'h3C, 8'h00, 1'b0, 4'd0, 4'h0);

    // Hit counter saturation (constant zero without the counters).
    write_entry(4'd0, 8'h11, 8'hFF, 4'h3);
    for (int n = 0; n < N_HITS; n++) begin
      send(OP_LOOKUP, '0, 8'h11, 8'hFF, '0);
      ack();
    end
    send(OP_READ, 4'd0, '0, '0, '0);
    check("hcnt_sat",  32'(rsp_hit_cnt), EXP_HCNT);
    check("hcnt_data", 32'(rsp_data), 3);
    ack();
    write_entry(4'd0, 8'h11, 8'hFF, 4'h3);
    send(OP_READ, 4'd0, '0, '0, '0);
    check("hcnt_clr", 32'(rsp_hit_cnt), 0);
    ack();

    // Reset in the middle of a flush.
    write_entry(4'd12, 8'h55, 8'hFF, 4'h6);
    req_valid = 1'b1;
    req_op    = OP_FLUSH;
    check("mr_pre_ready", 32'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mr_busy", 32'(req_ready), 0);
    rst_n = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 0);
    check("mr_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(OP_READ, 4'd12, '0, '0, '0);
    check("mr_rd_hit",  32'(rsp_hit), 0);
    check("mr_rd_key",  32'(rsp_key), 0);
    check("mr_rd_data", 32'(rsp_data), 0);
    ack();
    lookup_chk("mr_lk", 8'h55, 8'h00, 1'b0, 4'd0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
